// File: rtl/integration_scheduler.sv
// Integration-period scheduler: generates the integration tick, snapshots the
// correlator bank and streams a framed, XOR-checksummed dump over valid/ready.
module integration_scheduler #(
  parameter int          RESOLUTION         = 16,
  parameter int          NUM_INPUTS         = 12,
  parameter int          NUM_CORRELATORS    = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
  parameter int          INTEGRATION_CYCLES = 50000000,
  parameter logic [7:0]  HEADER             = 8'hA5,
  localparam int         SEL_W              = (NUM_CORRELATORS > 1) ? $clog2(NUM_CORRELATORS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  integration_clk_pulse,
  output logic                  snapshot,
  output logic [SEL_W-1:0]      corr_sel,
  input  logic [RESOLUTION-1:0] corr_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic [7:0]            overrun_count
);

  localparam int BYTES  = (RESOLUTION + 7) / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W  = $clog2(INTEGRATION_CYCLES);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(INTEGRATION_CYCLES - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BYTES - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_CORRELATORS - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HEADER   = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_CHECKSUM = 2'd3;

  logic [CNT_W-1:0]   r_icnt;
  logic [1:0]         r_state;
  logic [SEL_W-1:0]   r_corr_sel;
  logic [BIDX_W-1:0]  r_bidx;
  logic [7:0]         r_csum;
  logic [7:0]         r_ovr_cnt;

  logic               w_tick;
  logic               w_busy;
  logic               w_xfer;
  logic [BYTES*8-1:0] w_ext;
  logic [7:0]         w_data_byte;

  assign w_tick = enable && (r_icnt == CNT_LAST);
  assign w_busy = (r_state != S_IDLE);
  assign w_xfer = w_busy && tx_ready;
  assign w_ext  = (BYTES*8)'(corr_data);

  assign integration_clk_pulse = w_tick;
  assign snapshot              = w_tick && !w_busy;
  assign overrun               = w_tick && w_busy;
  assign busy                  = w_busy;
  assign tx_valid              = w_busy;
  assign corr_sel              = r_corr_sel;
  assign overrun_count         = r_ovr_cnt;

  always_comb begin
    w_data_byte = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (r_bidx == BIDX_W'(b)) w_data_byte = w_ext[b*8 +: 8];
    end
  end

  // Output byte is a pure function of state so it cannot move during a stall.
  always_comb begin
    case (r_state)
      S_HEADER:   tx_data = HEADER;
      S_DATA:     tx_data = w_data_byte;
      S_CHECKSUM: tx_data = r_csum;
      default:    tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_icnt <= '0;
    else if (!enable)          r_icnt <= '0;
    else if (r_icnt == CNT_LAST) r_icnt <= '0;
    else                       r_icnt <= r_icnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_corr_sel <= '0;
      r_bidx     <= '0;
      r_csum     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tick) r_state <= S_HEADER;
        end
        S_HEADER: begin
          if (w_xfer) begin
            r_state    <= S_DATA;
            r_corr_sel <= '0;
            r_bidx     <= BIDX_LAST;
            r_csum     <= '0;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_csum <= r_csum ^ w_data_byte;
            if (r_bidx != '0) begin
              r_bidx <= r_bidx - 1'b1;
            end else if (r_corr_sel < SEL_LAST) begin
              r_corr_sel <= r_corr_sel + 1'b1;
              r_bidx     <= BIDX_LAST;
            end else begin
              r_state <= S_CHECKSUM;
            end
          end
        end
        S_CHECKSUM: begin
          if (w_xfer) begin
            r_state    <= S_IDLE;
            r_corr_sel <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_ovr_cnt <= '0;
    else if (overrun && r_ovr_cnt != 8'hFF)  r_ovr_cnt <= r_ovr_cnt + 1'b1;
  end

endmodule

// File: tb/tb_integration_scheduler.sv
// Self-checking bench for integration_scheduler: randomized bank contents and
// backpressure checked cycle by cycle against a queue-based frame model.
module tb_integration_scheduler;

  localparam int         RES   = 16;
  localparam int         NIN   = 3;
  localparam int         NCORR = 3;
  localparam int         IC    = 20;
  localparam logic [7:0] HDR   = 8'hA5;
  localparam int         NB    = (RES + 7) / 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             tx_ready = 1'b0;
  logic             integration_clk_pulse;
  logic             snapshot;
  logic [1:0]       corr_sel;
  logic [RES-1:0]   corr_data;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             busy;
  logic             overrun;
  logic [7:0]       overrun_count;

  logic [RES-1:0]   bankLive [NCORR];
  logic [RES-1:0]   bankSnap [NCORR];

  int               testsRun = 0;
  int               testsFailed = 0;

  int               mCnt = 0;
  bit               mBusy = 0;
  int               mOvr = 0;
  logic [7:0]       expQ [$];
  logic [7:0]       gotBytes [$];
  bit               prevStall = 0;
  logic [7:0]       prevData = 8'h00;
  bit               tick;
  bit               wasBusy;
  int               cyc = 0;
  int               snapCount = 0;
  int               pulseCount = 0;
  int               lastSnapCyc = -1;

  logic [7:0]       expBasic [8];

  integration_scheduler #(
    .RESOLUTION(RES),
    .NUM_INPUTS(NIN),
    .NUM_CORRELATORS(NCORR),
    .INTEGRATION_CYCLES(IC),
    .HEADER(HDR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .integration_clk_pulse(integration_clk_pulse),
    .snapshot(snapshot),
    .corr_sel(corr_sel),
    .corr_data(corr_data),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .overrun(overrun),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  // Bank behaviour: latch live counters on snapshot, present the latched copy.
  always @(posedge clk) begin
    if (snapshot) begin
      for (int i = 0; i < NCORR; i++) bankSnap[i] <= bankLive[i];
    end
  end

  assign corr_data = (int'(corr_sel) < NCORR) ? bankSnap[int'(corr_sel)] : '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole frame as a byte list: header, each count MSB byte first, XOR of data.
  task automatic buildFrame();
    logic [7:0]      cs;
    logic [8*NB-1:0] v;
    cs = 8'h00;
    expQ.delete();
    expQ.push_back(HDR);
    for (int c = 0; c < NCORR; c++) begin
      v = (8*NB)'(bankLive[c]);
      for (int b = NB - 1; b >= 0; b--) begin
        expQ.push_back(v[b*8 +: 8]);
        cs = cs ^ v[b*8 +: 8];
      end
    end
    expQ.push_back(cs);
  endtask

  // Reference model and monitor, evaluated on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_tx_valid", tx_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_snapshot", snapshot, 0);
      checkOutput("rst_pulse", integration_clk_pulse, 0);
      checkOutput("rst_overrun", overrun, 0);
      checkOutput("rst_ovr_count", overrun_count, 0);
      checkOutput("rst_tx_data", tx_data, 0);
      checkOutput("rst_corr_sel", corr_sel, 0);
      mCnt = 0;
      mBusy = 0;
      mOvr = 0;
      expQ.delete();
      gotBytes.delete();
      prevStall = 0;
      cyc = 0;
      snapCount = 0;
      lastSnapCyc = -1;
    end else begin
      tick = enable && (mCnt == IC - 1);
      wasBusy = mBusy;
      checkOutput("pulse", integration_clk_pulse, tick);
      checkOutput("busy", busy, wasBusy);
      checkOutput("tx_valid", tx_valid, wasBusy);
      checkOutput("snapshot", snapshot, tick && !wasBusy);
      checkOutput("overrun", overrun, tick && wasBusy);
      checkOutput("ovr_count", overrun_count, mOvr);
      if (prevStall) checkOutput("stall_tx_data", tx_data, prevData);
      if (wasBusy) begin
        checkOutput("tx_data", tx_data, (expQ.size() > 0) ? 32'(expQ[0]) : 32'hFFFF_FFFF);
        if (tx_ready) begin
          gotBytes.push_back(tx_data);
          if (expQ.size() > 0) void'(expQ.pop_front());
          if (expQ.size() == 0) mBusy = 0;
        end
      end
      prevStall = wasBusy && !tx_ready;
      prevData  = tx_data;
      if (tick) pulseCount++;
      if (tick && wasBusy && mOvr < 255) mOvr++;
      if (tick && !wasBusy) begin
        buildFrame();
        mBusy = 1;
        snapCount++;
        lastSnapCyc = cyc;
      end
      mCnt = !enable ? 0 : ((mCnt == IC - 1) ? 0 : mCnt + 1);
      cyc++;
    end
  end

  task automatic applyStimulus(input int cycles, input int readyPct, input bit randBank);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      tx_ready = ($urandom_range(99) < readyPct);
      if (randBank) begin
        for (int i = 0; i < NCORR; i++) bankLive[i] = RES'($urandom);
      end
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while (busy && n < maxCycles) begin
      applyStimulus(1, 100, 1'b0);
      n++;
    end
    checkOutput("idle_timeout", busy, 0);
  endtask

  task automatic compareFrame(input string tag, input int base);
    for (int i = 0; i < 8; i++) begin
      if (base + i < gotBytes.size())
        checkOutput($sformatf("%s_byte%0d", tag, i), gotBytes[base + i], expBasic[i]);
      else
        checkOutput($sformatf("%s_byte%0d", tag, i), 32'hFFFF_FFFF, expBasic[i]);
    end
  endtask

  task automatic setBasicBank();
    bankLive[0] = 16'h1234;
    bankLive[1] = 16'h00FF;
    bankLive[2] = 16'hA001;
  endtask

  initial begin
    int base;
    int p0;
    int s0;
    int n;
    // Checksum 0x78 = 12^34^00^FF^A0^01
    expBasic = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'hFF, 8'hA0, 8'h01, 8'h78};
    setBasicBank();
    for (int i = 0; i < NCORR; i++) bankSnap[i] = '0;
    enable   = 1'b1;
    tx_ready = 1'b1;

    // Basic frame: snapshot at cycle IC-1 after release, then 8 bytes back to back.
    doReset();
    applyStimulus(30, 100, 1'b0);
    checkOutput("basic_snap_cycle", lastSnapCyc, IC - 1);
    checkOutput("basic_snap_count", snapCount, 1);
    checkOutput("basic_byte_count", gotBytes.size(), 8);
    compareFrame("basic", 0);

    // Backpressure: same bank, ready low about 30% of cycles.
    base = gotBytes.size();
    applyStimulus(20, 70, 1'b0);
    waitIdle(50);
    compareFrame("bp", base);

    // Long randomized run against the model.
    applyStimulus(600, 70, 1'b1);
    waitIdle(50);

    // Overrun: ready held low across three ticks.
    doReset();
    applyStimulus(3 * IC, 0, 1'b1);
    checkOutput("ovr_snap_count", snapCount, 1);
    checkOutput("ovr_count_two", overrun_count, 2);
    waitIdle(50);
    checkOutput("ovr_frame_len", gotBytes.size(), 8);

    // Saturation: well over 255 overruns.
    applyStimulus(IC * 270, 0, 1'b1);
    checkOutput("ovr_saturated", overrun_count, 255);
    waitIdle(50);

    // Enable gating: no ticks while low, first tick IC cycles after raising it.
    enable = 1'b0;
    p0 = pulseCount;
    applyStimulus(1000, 100, 1'b1);
    checkOutput("gate_no_ticks", pulseCount - p0, 0);
    checkOutput("gate_idle", busy, 0);
    enable = 1'b1;
    p0 = pulseCount;
    applyStimulus(IC - 1, 100, 1'b1);
    checkOutput("gate_no_early_tick", pulseCount - p0, 0);
    applyStimulus(1, 100, 1'b1);
    checkOutput("gate_first_tick", pulseCount - p0, 1);
    applyStimulus(3, 100, 1'b1);
    checkOutput("gate_midframe_busy", busy, 1);
    enable = 1'b0;
    p0 = pulseCount;
    s0 = gotBytes.size();
    applyStimulus(100, 100, 1'b1);
    checkOutput("gate_frame_done", busy, 0);
    checkOutput("gate_no_more_ticks", pulseCount - p0, 0);
    checkOutput("gate_rest_of_frame", gotBytes.size() - s0, 5);

    // Reset in the DATA state drops tx_valid without waiting for a clock.
    enable = 1'b1;
    n = 0;
    while (!busy && n < 3 * IC) begin
      applyStimulus(1, 100, 1'b1);
      n++;
    end
    checkOutput("rst_reach_busy", busy, 1);
    applyStimulus(3, 100, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_tx_valid", tx_valid, 0);
    checkOutput("rst_async_busy", busy, 0);
    checkOutput("rst_async_tx_data", tx_data, 0);
    setBasicBank();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(30, 100, 1'b0);
    checkOutput("rst_snap_cycle", lastSnapCyc, IC - 1);
    compareFrame("after_rst", 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
